toy_bus_pkt_lock_arb: RTL and testbench

//  N-input packet arbiter for the toy_bus fabric. Oldest-first grant via internal age matrix; grant

---
 rtl/toy_bus_pkt_lock_arb.sv | 184 ++++++++++++++++++
 tb/tb_toy_bus_pkt_lock_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_pkt_lock_arb.sv
// toy_bus packet arbiter: oldest-first age matrix, per-packet grant lock,
// and a single registered output slice.
module toy_bus_pkt_lock_arb #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned LOCK_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        in_vld,
    output logic [NUM_IN-1:0]        in_rdy,
    input  logic [NUM_IN-1:0]        in_opcode,
    input  logic [NUM_IN-1:0]        in_last,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN*ID_W-1:0]   in_src_id,
    input  logic [NUM_IN*ID_W-1:0]   in_tgt_id,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_opcode,
    output logic                     out_last,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_src_id,
    output logic [ID_W-1:0]          out_tgt_id,
    output logic [NUM_IN-1:0]        out_grant
);

    localparam int unsigned IW = $clog2(NUM_IN);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     lock_idx_q, lock_idx_d;
    logic [NUM_IN-1:0] age_q [NUM_IN];
    logic [NUM_IN-1:0] age_d [NUM_IN];

    logic [NUM_IN-1:0] oldest;
    logic [NUM_IN-1:0] lock_oh;
    logic [NUM_IN-1:0] sel;
    logic              slot_free;
    logic              acc;
    logic              age_upd;

    logic [IW-1:0]     win_idx;
    logic              win_last;
    logic              win_op;
    logic [DATA_W-1:0] win_data;
    logic [ID_W-1:0]   win_src;
    logic [ID_W-1:0]   win_tgt;

    logic              out_vld_q;
    logic              out_op_q;
    logic              out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ID_W-1:0]   out_src_q;
    logic [ID_W-1:0]   out_tgt_q;
    logic [NUM_IN-1:0] out_grant_q;

    // age_q[i][j] = 1 means requester j is older than i and beats it
    always_comb begin
        oldest = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            oldest[i] = in_vld[i] & ~|(age_q[i] & in_vld);
        end
        lock_oh = NUM_IN'(1) << lock_idx_q;
        sel     = (state_q == S_LOCKED) ? (lock_oh & in_vld) : oldest;
    end

    assign slot_free = ~out_vld_q | out_rdy;
    assign in_rdy    = sel & {NUM_IN{slot_free}};
    assign acc       = |(in_vld & in_rdy);

    always_comb begin
        win_idx  = '0;
        win_last = 1'b0;
        win_op   = 1'b0;
        win_data = '0;
        win_src  = '0;
        win_tgt  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel[i]) begin
                win_idx  = IW'(i);
                win_last = in_last[i];
                win_op   = in_opcode[i];
                win_data = in_data[i*DATA_W +: DATA_W];
                win_src  = in_src_id[i*ID_W +: ID_W];
                win_tgt  = in_tgt_id[i*ID_W +: ID_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if ((LOCK_EN != 0) && acc && !win_last) begin
                    state_d    = S_LOCKED;
                    lock_idx_d = win_idx;
                end
            end
            S_LOCKED: begin
                if (acc && win_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // winner becomes youngest: everyone beats it, it beats nobody
    assign age_upd = acc & (win_last | (LOCK_EN == 0));

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            age_d[i] = age_q[i];
        end
        if (age_upd) begin
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    if (IW'(i) == win_idx && i != j) begin
                        age_d[i][j] = 1'b1;
                    end
                    if (IW'(j) == win_idx) begin
                        age_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lock_idx_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    age_q[i][j] <= (j < i);
                end
            end
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            for (int i = 0; i < NUM_IN; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // output slice: load and drain may coincide for 1 beat/clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q   <= 1'b0;
            out_op_q    <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_tgt_q   <= '0;
            out_grant_q <= '0;
        end else if (acc) begin
            out_vld_q   <= 1'b1;
            out_op_q    <= win_op;
            out_last_q  <= win_last;
            out_data_q  <= win_data;
            out_src_q   <= win_src;
            out_tgt_q   <= win_tgt;
            out_grant_q <= sel;
        end else if (out_rdy) begin
            out_vld_q   <= 1'b0;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_opcode = out_op_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign out_src_id = out_src_q;
    assign out_tgt_id = out_tgt_q;
    assign out_grant  = out_grant_q;

endmodule

// File: tb/tb_toy_bus_pkt_lock_arb.sv
// Bench for toy_bus_pkt_lock_arb: per-requester beat queues drive the inputs,
// expected output beats are queued and compared as the slice drains.
module tb_toy_bus_pkt_lock_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_vld;
    logic [N-1:0]    in_opcode;
    logic [N-1:0]    in_last;
    logic [N*DW-1:0] in_data;
    logic [N*IW-1:0] in_src_id;
    logic [N*IW-1:0] in_tgt_id;
    logic            out_rdy;

    logic [N-1:0]    a_rdy, b_rdy;
    logic            a_vld, b_vld, a_op, b_op, a_last, b_last;
    logic [DW-1:0]   a_data, b_data;
    logic [IW-1:0]   a_src, b_src, a_tgt, b_tgt;
    logic [N-1:0]    a_gnt, b_gnt;

    logic            use_nl = 1'b0;
    logic [N-1:0]    m_rdy;
    logic            m_vld, m_op, m_last;
    logic [DW-1:0]   m_data;
    logic [IW-1:0]   m_src, m_tgt;
    logic [N-1:0]    m_gnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0]  en;
    logic [33:0]   srcq [N][$];
    logic [45:0]   exp_q [$];

    always #10 clk = ~clk;

    toy_bus_pkt_lock_arb #(.NUM_IN(N), .DATA_W(DW), .ID_W(IW), .LOCK_EN(1)) u_lk (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(a_rdy), .in_opcode(in_opcode),
        .in_last(in_last), .in_data(in_data),
        .in_src_id(in_src_id), .in_tgt_id(in_tgt_id),
        .out_vld(a_vld), .out_rdy(out_rdy), .out_opcode(a_op),
        .out_last(a_last), .out_data(a_data),
        .out_src_id(a_src), .out_tgt_id(a_tgt), .out_grant(a_gnt)
    );

    toy_bus_pkt_lock_arb #(.NUM_IN(N), .DATA_W(DW), .ID_W(IW), .LOCK_EN(0)) u_nl (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(b_rdy), .in_opcode(in_opcode),
        .in_last(in_last), .in_data(in_data),
        .in_src_id(in_src_id), .in_tgt_id(in_tgt_id),
        .out_vld(b_vld), .out_rdy(out_rdy), .out_opcode(b_op),
        .out_last(b_last), .out_data(b_data),
        .out_src_id(b_src), .out_tgt_id(b_tgt), .out_grant(b_gnt)
    );

    assign m_rdy  = use_nl ? b_rdy  : a_rdy;
    assign m_vld  = use_nl ? b_vld  : a_vld;
    assign m_op   = use_nl ? b_op   : a_op;
    assign m_last = use_nl ? b_last : a_last;
    assign m_data = use_nl ? b_data : a_data;
    assign m_src  = use_nl ? b_src  : a_src;
    assign m_tgt  = use_nl ? b_tgt  : a_tgt;
    assign m_gnt  = use_nl ? b_gnt  : a_gnt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkd(int r, int p, int b);
        return {8'(r), 8'(p), 16'(b)};
    endfunction

    task automatic add_pkt(int r, int p, int len);
        logic [33:0] w;
        for (int b = 0; b < len; b++) begin
            w = {b[0], (b == len - 1), mkd(r, p, b)};
            srcq[r].push_back(w);
        end
    endtask

    task automatic exp_beat(int r, int p, int b, logic last);
        logic [3:0]  g;
        logic [3:0]  s;
        logic [3:0]  t;
        logic [45:0] e;
        g = 4'(1 << r);
        s = 4'(r);
        t = 4'(r + 8);
        e = {g, last, b[0], s, t, mkd(r, p, b)};
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(int r, int p, int len);
        for (int b = 0; b < len; b++) exp_beat(r, p, b, b == len - 1);
    endtask

    task automatic drive();
        logic [33:0] w;
        for (int i = 0; i < N; i++) begin
            in_src_id[i*IW +: IW] = 4'(i);
            in_tgt_id[i*IW +: IW] = 4'(i + 8);
            if (en[i] && srcq[i].size() > 0) begin
                w = srcq[i][0];
                in_vld[i]    = 1'b1;
                in_opcode[i] = w[33];
                in_last[i]   = w[32];
                in_data[i*DW +: DW] = w[31:0];
            end else begin
                in_vld[i]    = 1'b0;
                in_opcode[i] = 1'b0;
                in_last[i]   = 1'b0;
                in_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic set_en(logic [N-1:0] m);
        en = m;
        drive();
        #1;
    endtask

    // one clock: record handshakes before the edge, advance sources after
    task automatic cyc();
        logic [N-1:0] f;
        @(negedge clk);
        f = in_vld & m_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (f[i]) void'(srcq[i].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic drain(string tag);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) cyc();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = '0;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) srcq[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_vld", 64'(m_vld), 64'd0);
        chk("rst_gnt", 64'(m_gnt), 64'd0);
        rst_n = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexp", 64'(m_vld), 64'd0);
            end else begin
                chk("sb_beat",
                    64'({m_gnt, m_last, m_op, m_src, m_tgt, m_data}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_vld = '0; in_opcode = '0; in_last = '0;
        in_data = '0; in_src_id = '0; in_tgt_id = '0;
        out_rdy = 1'b1;
        en = '0;

        // round-robin of single-beat packets
        do_reset();
        chk("t1_data0", 64'(m_data), 64'd0);
        add_pkt(0, 0, 1); add_pkt(0, 1, 1);
        add_pkt(1, 0, 1); add_pkt(2, 0, 1); add_pkt(3, 0, 1);
        exp_pkt(0, 0, 1); exp_pkt(1, 0, 1); exp_pkt(2, 0, 1);
        exp_pkt(3, 0, 1); exp_pkt(0, 1, 1);
        set_en(4'b1111);
        chk("t1_rdy0", 64'(m_rdy), 64'b0001);
        chk("t1_vld_pre", 64'(m_vld), 64'd0);
        cyc();
        chk("t1_vld_post", 64'(m_vld), 64'd1);
        drain("t1_drain");

        // locked multi-beat packet blocks an older requester
        do_reset();
        add_pkt(1, 0, 3); add_pkt(0, 0, 1);
        exp_pkt(1, 0, 3); exp_pkt(0, 0, 1);
        set_en(4'b0010);
        cyc();
        set_en(4'b0011);
        chk("t2_lock_b1", 64'(m_rdy), 64'b0010);
        cyc();
        chk("t2_lock_b2", 64'(m_rdy), 64'b0010);
        cyc();
        chk("t2_unlock", 64'(m_rdy), 64'b0001);
        drain("t2_drain");

        // back-pressure freezes the slice, then load and drain coincide
        do_reset();
        out_rdy = 1'b0;
        add_pkt(0, 0, 1); add_pkt(1, 0, 1);
        exp_pkt(0, 0, 1); exp_pkt(1, 0, 1);
        set_en(4'b0011);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("t3_rdy_stall", 64'(m_rdy), 64'd0);
            chk("t3_frozen", 64'(m_data), 64'(mkd(0, 0, 0)));
            cyc();
        end
        out_rdy = 1'b1;
        #1;
        chk("t3_rdy_resume", 64'(m_rdy), 64'b0010);
        cyc();
        chk("t3_same_cyc", 64'(m_data), 64'(mkd(1, 0, 0)));
        chk("t3_vld", 64'(m_vld), 64'd1);
        drain("t3_drain");

        // locked owner pauses mid-packet
        do_reset();
        add_pkt(2, 0, 3); add_pkt(3, 0, 1);
        exp_pkt(2, 0, 3); exp_pkt(3, 0, 1);
        set_en(4'b1100);
        cyc();
        set_en(4'b1000);
        chk("t4_hold_a", 64'(m_rdy), 64'd0);
        cyc();
        chk("t4_vld_fall", 64'(m_vld), 64'd0);
        chk("t4_hold_b", 64'(m_rdy), 64'd0);
        cyc();
        chk("t4_vld_low", 64'(m_vld), 64'd0);
        set_en(4'b1100);
        chk("t4_resume", 64'(m_rdy), 64'b0100);
        drain("t4_drain");

        // async reset mid-packet drops lock and slice
        do_reset();
        add_pkt(1, 0, 3); add_pkt(0, 0, 1); add_pkt(2, 0, 1);
        set_en(4'b0010);
        cyc();
        set_en(4'b0111);
        chk("t5_locked", 64'(m_rdy), 64'b0010);
        rst_n = 1'b0;
        #1;
        chk("t5_async_vld", 64'(m_vld), 64'd0);
        chk("t5_async_gnt", 64'(m_gnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_regrant", 64'(m_rdy), 64'b0001);
        exp_pkt(0, 0, 1);
        exp_beat(1, 0, 1, 1'b0);
        exp_beat(1, 0, 2, 1'b1);
        exp_pkt(2, 0, 1);
        drain("t5_drain");

        // no lock: beats interleave
        use_nl = 1'b1;
        do_reset();
        add_pkt(0, 0, 2); add_pkt(1, 0, 2);
        exp_beat(0, 0, 0, 1'b0);
        exp_beat(1, 0, 0, 1'b0);
        exp_beat(0, 0, 1, 1'b1);
        exp_beat(1, 0, 1, 1'b1);
        set_en(4'b0011);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
